// File: rtl/reg_writeback_pkg.sv
// Shared widths and bundle types for the write-back stage,
// the register file and decode.
package reg_writeback_pkg;

  localparam int DATA_W    = 16;
  localparam int IDX_W     = 5;
  localparam int REG_COUNT = 32;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    idx_t  idx;
    data_t data;
  } wb_entry_t;

  typedef struct packed {
    logic  hit;
    data_t data;
  } fwd_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Result handshake from ALU/memory into write-back.
// Upstream holds valid/index/data until ready.
interface reg_writeback_if;
  import reg_writeback_pkg::*;

  logic  valid;
  logic  ready;
  idx_t  index;
  data_t data;

  modport master (
    output valid,
    output index,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  index,
    input  data,
    output ready
  );

endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// Pending-write FIFO; entries are exposed oldest-first
// with per-entry valid so forwarding can scan by age.
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  wb_entry_t                 push_entry,
  input  logic                      pop,
  output wb_entry_t                 head,
  output wb_entry_t [DEPTH-1:0]     ents,
  output logic      [DEPTH-1:0]     ent_valid,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head = mem[rd_ptr];

  // age k = 0 is the head (oldest); pointer math wraps
  always_comb begin
    ents      = '0;
    ent_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ents[k]      = mem[rd_ptr + PW'(k)];
      ent_valid[k] = CW'(k) < count;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage: buffers results, drives the register
// file write port and forwards pending values to decode.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  reg_writeback_if.slave  res,
  input  logic            wb_hold,
  output idx_t            w_index,
  output data_t           w_data,
  output logic            w_enable,
  input  idx_t            rd_index1,
  input  idx_t            rd_index2,
  output logic            fwd_hit1,
  output data_t           fwd_data1,
  output logic            fwd_hit2,
  output data_t           fwd_data2,
  output logic            idle
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] ents;
  logic      [DEPTH-1:0] ent_valid;
  logic      [CW-1:0]    count;
  wb_entry_t             w_q;
  logic                  push;
  logic                  pop;
  fwd_t                  f1;
  fwd_t                  f2;

  assign res.ready = count != CW'(DEPTH);
  assign push      = res.valid && res.ready;
  assign pop       = (count != '0) && !wb_hold;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry ('{idx: res.index, data: res.data}),
    .pop        (pop),
    .head       (head),
    .ents       (ents),
    .ent_valid  (ent_valid),
    .count      (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      w_enable <= 1'b0;
      w_q      <= '0;
    end else begin
      w_enable <= pop;
      if (pop) begin
        w_q <= head;
      end
    end
  end

  assign w_index = w_q.idx;
  assign w_data  = w_q.data;
  assign idle    = (count == '0) && !w_enable;

  // oldest source first so later (newer) matches override
  function automatic fwd_t fwd_lookup(
    input idx_t                  ri,
    input wb_entry_t [DEPTH-1:0] e,
    input logic      [DEPTH-1:0] v,
    input logic                  we,
    input wb_entry_t             wq
  );
    fwd_t f;
    f = '0;
    if (we && wq.idx == ri) begin
      f.hit  = 1'b1;
      f.data = wq.data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (v[k] && e[k].idx == ri) begin
        f.hit  = 1'b1;
        f.data = e[k].data;
      end
    end
    return f;
  endfunction

  assign f1 = fwd_lookup(rd_index1, ents, ent_valid, w_enable, w_q);
  assign f2 = fwd_lookup(rd_index2, ents, ent_valid, w_enable, w_q);

  assign fwd_hit1  = f1.hit;
  assign fwd_data1 = f1.data;
  assign fwd_hit2  = f2.hit;
  assign fwd_data2 = f2.data;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with a write-port
// scoreboard checked by an independent monitor.
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  logic  clk;
  logic  reset;
  logic  wb_hold;
  idx_t  w_index;
  data_t w_data;
  logic  w_enable;
  idx_t  rd_index1;
  idx_t  rd_index2;
  logic  fwd_hit1;
  data_t fwd_data1;
  logic  fwd_hit2;
  data_t fwd_data2;
  logic  idle;

  int total;
  int bad;
  wb_entry_t sbq[$];

  reg_writeback_if rif();

  reg_writeback #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .res       (rif),
    .wb_hold   (wb_hold),
    .w_index   (w_index),
    .w_data    (w_data),
    .w_enable  (w_enable),
    .rd_index1 (rd_index1),
    .rd_index2 (rd_index2),
    .fwd_hit1  (fwd_hit1),
    .fwd_data1 (fwd_data1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data2 (fwd_data2),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after acceptance
  task automatic send(input idx_t i, input data_t d);
    int n;
    rif.valid = 1'b1;
    rif.index = i;
    rif.data  = d;
    n = 0;
    while (!rif.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rif.ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=0 want ready=1");
    end else begin
      sbq.push_back('{idx: i, data: d});
    end
    @(negedge clk);
    rif.valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
  endtask

  // monitor: every write-port pulse must match the oldest expectation
  initial begin
    wb_entry_t e;
    forever begin
      @(negedge clk);
      if (w_enable) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got idx=%0d data=%h want none",
                   w_index, w_data);
        end else begin
          e = sbq.pop_front();
          if (w_index !== e.idx || w_data !== e.data) begin
            bad++;
            $display("FAIL write_order: got idx=%0d data=%h want idx=%0d data=%h",
                     w_index, w_data, e.idx, e.data);
          end
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    wb_hold   = 1'b0;
    rif.valid = 1'b0;
    rif.index = '0;
    rif.data  = '0;
    rd_index1 = '0;
    rd_index2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", rif.ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_wen", w_enable, 0);
    chk("rst_widx", w_index, 0);
    chk("rst_wdata", w_data, 0);
    chk("rst_hit1", fwd_hit1, 0);
    chk("rst_hit2", fwd_hit2, 0);
    reset = 1'b0;
    @(negedge clk);

    // single write latency
    send(5'd3, 16'h1234);
    chk("t1_wen_early", w_enable, 0);
    @(negedge clk);
    chk("t1_wen", w_enable, 1);
    chk("t1_widx", w_index, 3);
    chk("t1_wdata", w_data, 16'h1234);
    @(negedge clk);
    chk("t1_idle", idle, 1);
    chk("t1_wen_off", w_enable, 0);

    // hold fills FIFO, release drains in order
    wb_hold = 1'b1;
    send(5'd1, 16'h0101);
    send(5'd2, 16'h0202);
    rif.valid = 1'b1;
    rif.index = 5'd4;
    rif.data  = 16'h0404;
    chk("t2_full_ready", rif.ready, 0);
    @(negedge clk);
    chk("t2_full_ready2", rif.ready, 0);
    chk("t2_hold_wen", w_enable, 0);
    wb_hold = 1'b0;
    @(negedge clk);
    chk("t2_pop1_wen", w_enable, 1);
    chk("t2_pop1_idx", w_index, 1);
    chk("t2_ready_back", rif.ready, 1);
    sbq.push_back('{idx: 5'd4, data: 16'h0404});
    @(negedge clk);
    rif.valid = 1'b0;
    chk("t2_pop2_wen", w_enable, 1);
    chk("t2_pop2_idx", w_index, 2);
    drain();
    @(negedge clk);

    // forwarding, newest wins
    wb_hold = 1'b1;
    send(5'd5, 16'h00AA);
    send(5'd5, 16'h00BB);
    rd_index1 = 5'd5;
    rd_index2 = 5'd6;
    #1;
    chk("t3_hit1", fwd_hit1, 1);
    chk("t3_data1", fwd_data1, 16'h00BB);
    chk("t3_hit2", fwd_hit2, 0);
    chk("t3_data2", fwd_data2, 0);
    wb_hold = 1'b0;
    @(negedge clk);
    chk("t3_wstage_aa_fwd", fwd_data1, 16'h00BB);
    @(negedge clk);
    chk("t3_wstage_hit", fwd_hit1, 1);
    chk("t3_wstage_bb", fwd_data1, 16'h00BB);
    @(negedge clk);
    chk("t3_gone_hit", fwd_hit1, 0);
    chk("t3_gone_data", fwd_data1, 0);
    rd_index1 = '0;
    rd_index2 = '0;

    // streaming from full: simultaneous push/pop
    wb_hold = 1'b1;
    send(5'd20, 16'hA000);
    send(5'd21, 16'hA001);
    wb_hold = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(idx_t'(i + 7), 16'hC000 + 16'(i * 16'h0111));
    end
    drain();
    @(negedge clk);
    chk("t4_idle", idle, 1);

    // reset discards pending writes
    wb_hold = 1'b1;
    send(5'd9, 16'h0909);
    send(5'd10, 16'h1010);
    rd_index1 = 5'd9;
    rd_index2 = 5'd10;
    #1;
    chk("t5_pre_hit1", fwd_hit1, 1);
    chk("t5_pre_hit2", fwd_hit2, 1);
    reset = 1'b1;
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("t5_wen", w_enable, 0);
    chk("t5_ready", rif.ready, 1);
    chk("t5_hit1", fwd_hit1, 0);
    chk("t5_hit2", fwd_hit2, 0);
    wb_hold = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_idle", idle, 1);
    rd_index1 = '0;
    rd_index2 = '0;

    // register 0 is ordinary
    send(5'd0, 16'hFFFF);
    @(negedge clk);
    chk("t6_wen", w_enable, 1);
    chk("t6_idx", w_index, 0);
    chk("t6_data", w_data, 16'hFFFF);
    drain();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
